// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared widths and the writeback source encoding for the register-file
// writeback scheduler.
package regfile_pkg;

  localparam int ADDR_W   = 2;
  localparam int DATA_W   = 4;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_t;

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Bundles the issue port, both writeback request ports, the register-file
// write port and the scoreboard status.
interface regfile_wb_scheduler_if;
  import regfile_pkg::*;

  logic                issue_valid;
  logic [ADDR_W-1:0]   issue_rs1;
  logic [ADDR_W-1:0]   issue_rs2;
  logic [ADDR_W-1:0]   issue_rd;
  logic                issue_stall;

  logic                a_valid;
  logic [ADDR_W-1:0]   a_rd;
  logic [DATA_W-1:0]   a_data;
  logic                a_ready;

  logic                m_valid;
  logic [ADDR_W-1:0]   m_rd;
  logic [DATA_W-1:0]   m_data;
  logic                m_ready;

  logic                reg_write;
  logic [ADDR_W-1:0]   write_reg;
  logic [DATA_W-1:0]   write_data;
  logic [NUM_REGS-1:0] busy;
  logic                wb_err;

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd,
    input  a_valid, a_rd, a_data,
    input  m_valid, m_rd, m_data,
    output issue_stall, a_ready, m_ready,
    output reg_write, write_reg, write_data, busy, wb_err
  );

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd,
    output a_valid, a_rd, a_data,
    output m_valid, m_rd, m_data,
    input  issue_stall, a_ready, m_ready,
    input  reg_write, write_reg, write_data, busy, wb_err
  );

endinterface

// File: rtl/regfile_wb_scheduler_arb.sv
// Two-request round-robin arbiter. req[0]/gnt[0] is the ALU source,
// req[1]/gnt[1] the load source.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  wb_src_t last_q;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_q == SRC_ALU) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // Reset to "load granted last" so the ALU wins the first contention.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= SRC_MEM;
    end else if (gnt[0]) begin
      last_q <= SRC_ALU;
    end else if (gnt[1]) begin
      last_q <= SRC_MEM;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the register-file write port between ALU and load writeback and
// keeps the busy scoreboard that stalls issue on RAW/WAW hazards.
module regfile_wb_scheduler
  import regfile_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  regfile_wb_scheduler_if.slave   bus
);

  logic [1:0]          req;
  logic [1:0]          gnt;
  logic                grant_any;
  logic [ADDR_W-1:0]   sel_rd;
  logic [DATA_W-1:0]   sel_data;
  logic                issue_hit;
  logic                issue_stall;
  logic                issue_accept;

  logic                reg_write_q;
  logic [ADDR_W-1:0]   write_reg_q;
  logic [DATA_W-1:0]   write_data_q;
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                wb_err_q;

  // Requests are masked during reset so nothing is accepted and then dropped.
  assign req = {bus.m_valid, bus.a_valid} & {2{rst_n}};

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt)
  );

  assign grant_any = gnt[0] | gnt[1];
  assign sel_rd    = gnt[1] ? bus.m_rd   : bus.a_rd;
  assign sel_data  = gnt[1] ? bus.m_data : bus.a_data;

  assign issue_hit    = busy_q[bus.issue_rs1] | busy_q[bus.issue_rs2] | busy_q[bus.issue_rd];
  assign issue_stall  = bus.issue_valid & issue_hit;
  assign issue_accept = bus.issue_valid & ~issue_hit;

  always_comb begin
    busy_d = busy_q;
    if (reg_write_q) begin
      busy_d[write_reg_q] = 1'b0;
    end
    if (issue_accept) begin
      busy_d[bus.issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      busy_q       <= '0;
      wb_err_q     <= 1'b0;
    end else begin
      reg_write_q <= grant_any;
      if (grant_any) begin
        write_reg_q  <= sel_rd;
        write_data_q <= sel_data;
      end
      busy_q <= busy_d;
      // Flagged on the edge that commits a write nobody reserved.
      if (reg_write_q && !busy_q[write_reg_q]) begin
        wb_err_q <= 1'b1;
      end
    end
  end

  assign bus.issue_stall = issue_stall;
  assign bus.a_ready     = gnt[0];
  assign bus.m_ready     = gnt[1];
  assign bus.reg_write   = reg_write_q;
  assign bus.write_reg   = write_reg_q;
  assign bus.write_data  = write_data_q;
  assign bus.busy        = busy_q;
  assign bus.wb_err      = wb_err_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: expected writes are queued by the
// stimulus and popped by a write-port monitor; status signals are checked inline.
module tb_regfile_wb_scheduler;
  import regfile_pkg::*;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic clk;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;
  wr_t  exp_q[$];

  regfile_wb_scheduler_if bus ();

  regfile_wb_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic wr_t mk(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
    wr_t w;
    w.rd   = r;
    w.data = d;
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    bus.a_valid     = 1'b0;
    bus.m_valid     = 1'b0;
    bus.issue_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic issue(input logic [1:0] rs1, input logic [1:0] rs2, input logic [1:0] rd);
    bus.issue_valid = 1'b1;
    bus.issue_rs1   = rs1;
    bus.issue_rs2   = rs2;
    bus.issue_rd    = rd;
  endtask

  // Write-port monitor
  always @(negedge clk) begin
    if (bus.reg_write === 1'b1) begin : mon
      wr_t e;
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_write: got reg %0d data %0h expected no write",
                 bus.write_reg, bus.write_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_reg", 32'(bus.write_reg), 32'(e.rd));
        chk("wr_data", 32'(bus.write_data), 32'(e.data));
      end
    end
  end

  initial begin
    rst_n           = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_rs1   = '0;
    bus.issue_rs2   = '0;
    bus.issue_rd    = '0;
    bus.a_valid     = 1'b1;
    bus.a_rd        = 2'd0;
    bus.a_data      = 4'h1;
    bus.m_valid     = 1'b1;
    bus.m_rd        = 2'd3;
    bus.m_data      = 4'h2;

    // Reset with both sources requesting
    @(negedge clk);
    chk("rst_reg_write", 32'(bus.reg_write), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_a_ready", 32'(bus.a_ready), 0);
    chk("rst_m_ready", 32'(bus.m_ready), 0);
    chk("rst_wb_err", 32'(bus.wb_err), 0);
    step();
    rst_n = 1'b1;
    exp_q.push_back(mk(2'd0, 4'h1));
    @(negedge clk);
    chk("first_a_ready", 32'(bus.a_ready), 1);
    chk("first_m_ready", 32'(bus.m_ready), 0);
    step();
    bus.a_valid = 1'b0;
    exp_q.push_back(mk(2'd3, 4'h2));
    @(negedge clk);
    chk("m_alone_ready", 32'(bus.m_ready), 1);
    step();
    bus.m_valid = 1'b0;
    step();

    // Single write
    do_reset();
    issue(2'd0, 2'd0, 2'd2);
    @(negedge clk);
    chk("single_issue_stall", 32'(bus.issue_stall), 0);
    step();
    bus.issue_valid = 1'b0;
    bus.a_valid     = 1'b1;
    bus.a_rd        = 2'd2;
    bus.a_data      = 4'hA;
    exp_q.push_back(mk(2'd2, 4'hA));
    @(negedge clk);
    chk("single_busy", 32'(bus.busy), 32'h4);
    chk("single_a_ready", 32'(bus.a_ready), 1);
    step();
    bus.a_valid = 1'b0;
    @(negedge clk);
    chk("single_reg_write", 32'(bus.reg_write), 1);
    step();
    @(negedge clk);
    chk("single_busy_clear", 32'(bus.busy), 0);
    chk("single_wb_err", 32'(bus.wb_err), 0);

    // Contention
    do_reset();
    issue(2'd0, 2'd0, 2'd1);
    step();
    issue(2'd0, 2'd0, 2'd3);
    step();
    bus.issue_valid = 1'b0;
    bus.a_valid     = 1'b1;
    bus.a_rd        = 2'd1;
    bus.a_data      = 4'h3;
    bus.m_valid     = 1'b1;
    bus.m_rd        = 2'd3;
    bus.m_data      = 4'h5;
    @(negedge clk);
    chk("cont_busy", 32'(bus.busy), 32'hA);
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      chk($sformatf("cont_a_ready_%0d", i), 32'(bus.a_ready), 32'((i % 2) == 0));
      chk($sformatf("cont_m_ready_%0d", i), 32'(bus.m_ready), 32'((i % 2) == 1));
      if ((i % 2) == 0) exp_q.push_back(mk(2'd1, 4'h3));
      else              exp_q.push_back(mk(2'd3, 4'h5));
      step();
    end
    bus.a_valid = 1'b0;
    bus.m_valid = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("cont_busy_clear", 32'(bus.busy), 0);
    chk("cont_wb_err", 32'(bus.wb_err), 1);

    // Hazard stall
    do_reset();
    issue(2'd0, 2'd0, 2'd1);
    step();
    issue(2'd1, 2'd0, 2'd2);
    @(negedge clk);
    chk("haz_stall", 32'(bus.issue_stall), 1);
    chk("haz_busy", 32'(bus.busy), 32'h2);
    step();
    bus.a_valid = 1'b1;
    bus.a_rd    = 2'd1;
    bus.a_data  = 4'h9;
    exp_q.push_back(mk(2'd1, 4'h9));
    @(negedge clk);
    chk("haz_busy_hold", 32'(bus.busy), 32'h2);
    chk("haz_a_ready", 32'(bus.a_ready), 1);
    step();
    bus.a_valid = 1'b0;
    @(negedge clk);
    chk("haz_stall_no_bypass", 32'(bus.issue_stall), 1);
    step();
    @(negedge clk);
    chk("haz_stall_clear", 32'(bus.issue_stall), 0);
    chk("haz_busy_zero", 32'(bus.busy), 0);
    step();
    bus.issue_valid = 1'b0;
    @(negedge clk);
    chk("haz_busy_rd", 32'(bus.busy), 32'h4);

    // Writeback to non-busy register
    do_reset();
    bus.m_valid = 1'b1;
    bus.m_rd    = 2'd0;
    bus.m_data  = 4'h7;
    exp_q.push_back(mk(2'd0, 4'h7));
    @(negedge clk);
    chk("err_m_ready", 32'(bus.m_ready), 1);
    chk("err_wb_err_pre", 32'(bus.wb_err), 0);
    step();
    bus.m_valid = 1'b0;
    @(negedge clk);
    chk("err_reg_write", 32'(bus.reg_write), 1);
    step();
    @(negedge clk);
    chk("err_wb_err", 32'(bus.wb_err), 1);
    repeat (3) step();
    @(negedge clk);
    chk("err_wb_err_sticky", 32'(bus.wb_err), 1);
    rst_n = 1'b0;
    step();
    @(negedge clk);
    chk("err_wb_err_reset", 32'(bus.wb_err), 0);

    // Reset one cycle after a grant
    do_reset();
    issue(2'd0, 2'd0, 2'd2);
    step();
    bus.issue_valid = 1'b0;
    bus.a_valid     = 1'b1;
    bus.a_rd        = 2'd2;
    bus.a_data      = 4'h6;
    exp_q.push_back(mk(2'd2, 4'h6));
    @(negedge clk);
    chk("mid_a_ready", 32'(bus.a_ready), 1);
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_reg_write_inflight", 32'(bus.reg_write), 1);
    chk("mid_a_ready_rst", 32'(bus.a_ready), 0);
    step();
    @(negedge clk);
    chk("mid_reg_write", 32'(bus.reg_write), 0);
    chk("mid_busy", 32'(bus.busy), 0);
    chk("mid_write_reg", 32'(bus.write_reg), 0);
    chk("mid_write_data", 32'(bus.write_data), 0);
    bus.a_valid = 1'b0;
    rst_n       = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("end_reg_write", 32'(bus.reg_write), 0);
    chk("end_queue_empty", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
